bulls_cows_game_p: RTL and testbench

//  Parametrised Bulls & Cows game controller for the board top level: 2..4 players, N-digit BCD secrets, a round limit with draw.

---
 rtl/bulls_cows_game_p_if.sv | 16 +
 rtl/bulls_cows_game_p.sv | 151 +++++++++++++++
 tb/tb_bulls_cows_game_p.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bulls_cows_game_p_if.sv
// bulls_cows_game_p_if: switch/enter inputs and display/status outputs of the game controller
interface bulls_cows_game_p_if #(
    parameter int N_DIGITS  = 4,
    parameter int N_PLAYERS = 2
);
    logic [4*N_DIGITS-1:0] sw;
    logic                  ssl;
    logic [47:0]           disp;
    logic [N_PLAYERS-1:0]  win;
    logic                  draw;
    logic                  err;
    logic [1:0]            cur_player;
    logic [6:0]            round_cnt;
    modport master (output sw, ssl, input disp, win, draw, err, cur_player, round_cnt);
    modport slave  (input sw, ssl, output disp, win, draw, err, cur_player, round_cnt);
endinterface

// File: rtl/bulls_cows_game_p.sv
// bulls_cows_game_p: multi-player Bulls & Cows controller with round limit and draw
module bulls_cows_game_p #(
    parameter int N_DIGITS   = 4,
    parameter int N_PLAYERS  = 2,
    parameter int MAX_ROUNDS = 10
) (
    input  logic clock,
    input  logic reset,
    bulls_cows_game_p_if.slave bus
);
    localparam int W = 4*N_DIGITS;
    localparam logic [5:0] L_DASH = 6'b111111, L_U = 6'b011111, L_S = 6'b011011, L_P = 6'b010101;
    localparam logic [5:0] L_G = 6'b001101, L_C = 6'b011001, L_B = 6'b010111, L_E = 6'b011101, L_D = 6'b011110;
    typedef enum logic [2:0] {SETUP, TURN, RESULT, WIN, DRAW} state_t;
    state_t state, state_n;
    logic [1:0] player, player_n, tgt;
    logic [W-1:0] secret [4];
    logic [W-1:0] secret_n [4];
    logic [W-1:0] tgt_s;
    logic [3:0] bulls, cows, bulls_n, cows_n, bulls_c, cows_c, pn;
    logic [N_PLAYERS-1:0] win, win_n;
    logic draw, draw_n, err, err_n, ssl_q, enter_rise, bad, dup, hit, last;
    logic [6:0] rnd, rnd_n;
    logic [47:0] disp, disp_n;

    function automatic logic [5:0] dg(input logic [3:0] v);
        return {1'b0, v, 1'b0};
    endfunction

    assign enter_rise     = bus.ssl & ~ssl_q;
    assign last           = player == 2'(N_PLAYERS-1);
    assign tgt            = last ? 2'd0 : player + 2'd1;
    assign tgt_s          = secret[tgt];
    assign pn             = {2'b00, player} + 4'd1;
    assign bus.disp       = disp;
    assign bus.win        = win;
    assign bus.draw       = draw;
    assign bus.err        = err;
    assign bus.cur_player = player;
    assign bus.round_cnt  = rnd;

    // entry checks (BCD range, repeated digits) and scoring of sw against the target secret
    always_comb begin
        bad = 1'b0;
        dup = 1'b0;
        hit = 1'b0;
        bulls_c = 4'd0;
        cows_c = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            bad = bad | (bus.sw[4*k +: 4] > 4'd9);
            hit = 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                if (i > k) dup = dup | (bus.sw[4*k +: 4] == bus.sw[4*i +: 4]);
                if (i != k) hit = hit | (bus.sw[4*k +: 4] == tgt_s[4*i +: 4]);
            end
            bulls_c = bulls_c + 4'(bus.sw[4*k +: 4] == tgt_s[4*k +: 4]);
            cows_c = cows_c + 4'(bus.sw[4*k +: 4] != tgt_s[4*k +: 4] && hit);
        end
    end

    // next state, game bookkeeping and display contents for the current state
    always_comb begin
        state_n = state;
        player_n = player;
        secret_n = secret;
        bulls_n = bulls;
        cows_n = cows;
        win_n = win;
        draw_n = draw;
        err_n = 1'b0;
        rnd_n = rnd;
        if (enter_rise) begin
            case (state)
                SETUP: begin
                    if (bad || dup) err_n = 1'b1;
                    else begin
                        secret_n[player] = bus.sw;
                        state_n = last ? TURN : SETUP;
                        player_n = last ? 2'd0 : player + 2'd1;
                    end
                end
                TURN: begin
                    if (bad) err_n = 1'b1;
                    else begin
                        bulls_n = bulls_c;
                        cows_n = cows_c;
                        if (bulls_c == 4'(N_DIGITS)) begin
                            win_n = N_PLAYERS'(1) << player;
                            state_n = WIN;
                        end else state_n = RESULT;
                    end
                end
                RESULT: begin
                    bulls_n = 4'd0;
                    cows_n = 4'd0;
                    if (last) rnd_n = rnd + 7'd1;
                    if (last && MAX_ROUNDS != 0 && rnd + 7'd1 == 7'(MAX_ROUNDS)) begin
                        draw_n = 1'b1;
                        state_n = DRAW;
                    end else begin
                        state_n = TURN;
                        player_n = tgt;
                    end
                end
                default: begin
                    win_n = '0;
                    draw_n = 1'b0;
                    rnd_n = 7'd0;
                    player_n = 2'd0;
                    state_n = SETUP;
                end
            endcase
        end
        case (state)
            SETUP:   disp_n = {L_DASH, L_DASH, L_DASH, L_P, dg(pn), L_DASH, L_S, L_U};
            TURN:    disp_n = {L_DASH, L_DASH, L_DASH, L_DASH, L_P, dg(pn), L_DASH, L_G};
            RESULT:  disp_n = {dg(4'(rnd % 7'd10)), dg(4'(rnd / 7'd10)), L_DASH, dg(bulls), L_B, L_DASH, dg(cows), L_C};
            WIN:     disp_n = {L_DASH, L_DASH, dg(pn), L_P, L_DASH, L_B, L_DASH, L_E};
            default: disp_n = {L_DASH, L_DASH, L_DASH, L_DASH, L_DASH, L_D, L_DASH, L_D};
        endcase
    end

    // state and datapath registers; reset aborts straight back to setup
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= SETUP;
            player <= 2'd0;
            secret <= '{default: '0};
            bulls <= 4'd0;
            cows <= 4'd0;
            win <= '0;
            draw <= 1'b0;
            err <= 1'b0;
            rnd <= 7'd0;
            disp <= '1;
            ssl_q <= 1'b0;
        end else begin
            state <= state_n;
            player <= player_n;
            secret <= secret_n;
            bulls <= bulls_n;
            cows <= cows_n;
            win <= win_n;
            draw <= draw_n;
            err <= err_n;
            rnd <= rnd_n;
            disp <= disp_n;
            ssl_q <= bus.ssl;
        end
    end
endmodule

// File: tb/tb_bulls_cows_game_p.sv
// tb_bulls_cows_game_p: directed checks of three game configurations
module tb_bulls_cows_game_p;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic err_seen;
    localparam logic [5:0] D = 6'b111111, U = 6'b011111, S = 6'b011011, P = 6'b010101;
    localparam logic [5:0] G = 6'b001101, C = 6'b011001, B = 6'b010111, E = 6'b011101, DL = 6'b011110;

    always #5 clock = ~clock;

    bulls_cows_game_p_if #(.N_DIGITS(4), .N_PLAYERS(2)) ia ();
    bulls_cows_game_p_if #(.N_DIGITS(4), .N_PLAYERS(3)) ib ();
    bulls_cows_game_p_if #(.N_DIGITS(6), .N_PLAYERS(4)) ic ();

    bulls_cows_game_p #(.N_DIGITS(4), .N_PLAYERS(2), .MAX_ROUNDS(10)) dut_a (.clock(clock), .reset(reset), .bus(ia));
    bulls_cows_game_p #(.N_DIGITS(4), .N_PLAYERS(3), .MAX_ROUNDS(1))  dut_b (.clock(clock), .reset(reset), .bus(ib));
    bulls_cows_game_p #(.N_DIGITS(6), .N_PLAYERS(4), .MAX_ROUNDS(0))  dut_c (.clock(clock), .reset(reset), .bus(ic));

    function automatic logic [5:0] dg(input int v);
        return {1'b0, 4'(v), 1'b0};
    endfunction

    function automatic logic [47:0] dsp(input logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8);
        return {d8, d7, d6, d5, d4, d3, d2, d1};
    endfunction

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // press enter on DUT w with sw=v, ssl held for hold cycles; returns one cycle after disp settles
    task automatic press(input int w, input logic [23:0] v, input int hold = 1);
        @(negedge clock);
        if (w == 0) begin ia.sw = v[15:0]; ia.ssl = 1'b1; end
        else if (w == 1) begin ib.sw = v[15:0]; ib.ssl = 1'b1; end
        else begin ic.sw = v; ic.ssl = 1'b1; end
        @(negedge clock);
        err_seen = (w == 0) ? ia.err : (w == 1) ? ib.err : ic.err;
        repeat (hold - 1) @(negedge clock);
        ia.ssl = 1'b0;
        ib.ssl = 1'b0;
        ic.ssl = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        ia.sw = '0; ia.ssl = 1'b0;
        ib.sw = '0; ib.ssl = 1'b0;
        ic.sw = '0; ic.ssl = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_disp", ia.disp, '1);
        check("rst_win", 48'(ia.win), 0);
        check("rst_err", 48'(ia.err), 0);
        check("rst_round", 48'(ia.round_cnt), 0);
        reset = 1'b0;
        @(negedge clock);
        check("setup0", ia.disp, dsp(U, S, D, dg(1), P, D, D, D));
        press(0, 24'h1123);
        check("dup_err", 48'(err_seen), 1);
        check("err_pulse", 48'(ia.err), 0);
        check("dup_stay", 48'(ia.cur_player), 0);
        press(0, 24'h12A4);
        check("hex_err", 48'(err_seen), 1);
        check("hex_stay", ia.disp, dsp(U, S, D, dg(1), P, D, D, D));
        press(0, 24'h1234);
        check("ok_noerr", 48'(err_seen), 0);
        check("setup1", ia.disp, dsp(U, S, D, dg(2), P, D, D, D));
        check("setup1_p", 48'(ia.cur_player), 1);
        press(0, 24'h5678);
        check("turn0", ia.disp, dsp(G, D, dg(1), P, D, D, D, D));
        press(0, 24'h5687, 20);
        check("res_c2b2", ia.disp, dsp(C, dg(2), D, B, dg(2), D, dg(0), dg(0)));
        press(0, 24'h0);
        check("turn1", ia.disp, dsp(G, D, dg(2), P, D, D, D, D));
        check("turn1_p", 48'(ia.cur_player), 1);
        check("turn1_rnd", 48'(ia.round_cnt), 0);
        press(0, 24'h12B4);
        check("guess_err", 48'(err_seen), 1);
        press(0, 24'h1111);
        check("res_c3b1", ia.disp, dsp(C, dg(3), D, B, dg(1), D, dg(0), dg(0)));
        press(0, 24'h0);
        check("rot_rnd", 48'(ia.round_cnt), 1);
        check("rot_p", 48'(ia.cur_player), 0);
        press(0, 24'h0000);
        check("res_rnd1", ia.disp, dsp(C, dg(0), D, B, dg(0), D, dg(0), dg(1)));
        press(0, 24'h0);
        press(0, 24'h1234);
        check("win_p2", 48'(ia.win), 48'h2);
        check("win_disp", ia.disp, dsp(E, D, B, D, P, dg(2), D, D));
        check("win_rnd", 48'(ia.round_cnt), 1);
        press(0, 24'h0);
        check("win_clr", 48'(ia.win), 0);
        check("win_rnd_clr", 48'(ia.round_cnt), 0);
        check("win_setup", ia.disp, dsp(U, S, D, dg(1), P, D, D, D));
        press(0, 24'h1234);
        press(0, 24'h5678);
        press(0, 24'h0000);
        press(0, 24'h0);
        press(0, 24'h0000);
        check("pre_rst_p", 48'(ia.cur_player), 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_disp", ia.disp, '1);
        check("mid_rst_p", 48'(ia.cur_player), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        press(1, 24'h1234);
        press(1, 24'h5678);
        press(1, 24'h9012);
        check("b_turn0", ib.disp, dsp(G, D, dg(1), P, D, D, D, D));
        press(1, 24'h0000);
        press(1, 24'h0);
        press(1, 24'h3456);
        press(1, 24'h0);
        check("b_turn2_p", 48'(ib.cur_player), 2);
        press(1, 24'h5678);
        check("b_nodraw", 48'(ib.draw), 0);
        press(1, 24'h0);
        check("b_draw", 48'(ib.draw), 1);
        check("b_draw_rnd", 48'(ib.round_cnt), 1);
        check("b_draw_disp", ib.disp, dsp(DL, D, DL, D, D, D, D, D));
        press(1, 24'h0);
        check("b_draw_clr", 48'(ib.draw), 0);
        check("b_rnd_clr", 48'(ib.round_cnt), 0);
        check("b_setup", ib.disp, dsp(U, S, D, dg(1), P, D, D, D));
        press(2, 24'h987654);
        press(2, 24'h012345);
        press(2, 24'h123456);
        press(2, 24'h234567);
        press(2, 24'h543210);
        check("c_res_c6", ic.disp, dsp(C, dg(6), D, B, dg(0), D, dg(0), dg(0)));
        press(2, 24'h0);
        for (int t = 0; t < 3; t++) begin
            press(2, 24'h000000);
            press(2, 24'h0);
        end
        check("c_rnd", 48'(ic.round_cnt), 1);
        check("c_p0", 48'(ic.cur_player), 0);
        press(2, 24'h012345);
        check("c_win", 48'(ic.win), 48'h1);
        check("c_win_disp", ic.disp, dsp(E, D, B, D, P, dg(1), D, D));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
